imm_gen_stage: RTL and testbench
================================

Name: imm_gen_stage

Overview:
- Registered, parametrised immediate-generation stage between the decoder and the execute/branch unit of the NPC core.
- Supports every RV32I/RV64I immediate format plus CSR zimm and shift-amount forms.
- Computes the PC-relative target `pc + imm` in the same stage and flags malformed immediates.
- Decoupled valid/ready on both sides; 2-entry skid buffer so `in_ready` is a pure register output.

Parameters:
- XLEN, 32, datapath width of imm/pc/target; legal values 32 or 64.
- FMT_W, 3, width of the format-select field.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous pipeline flush (branch mispredict/trap)
- in_valid  input  1  upstream holds a valid instruction
- in_ready  output  1  stage can accept this cycle
- in_inst  input  32  raw instruction word
- in_pc  input  XLEN  instruction PC
- in_fmt  input  FMT_W  0=I, 1=S, 2=B, 3=U, 4=J, 5=Z(zimm), 6=SH(shamt), 7=reserved
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts
- out_imm  output  XLEN  extended immediate
- out_pc  output  XLEN  pass-through PC
- out_target  output  XLEN  `out_pc + out_imm`, modulo 2^XLEN
- out_err  output  1  malformed immediate/format

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0; skid entry invalid; in_ready=1.
  - out_imm, out_pc, out_target = 0; out_err=0.
- Immediate formation (combinational on input side, registered into the entry). "sext" means sign-extend to XLEN:
  - I: sext(inst[31:20]).
  - S: sext({inst[31:25], inst[11:7]}).
  - B: sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}).
  - U: sext({inst[31:12], 12'b0}); upper bits replicate inst[31] when XLEN=64.
  - J: sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
  - Z: zero-extended inst[19:15].
  - SH, XLEN=64: zero-extended inst[25:20].
  - SH, XLEN=32: zero-extended inst[24:20]; err=1 if inst[25]=1.
  - fmt 7: imm=0, err=1.
- Target: full-width XLEN adder, registered together with the immediate; carry out discarded.
- Latency: 1 cycle. An input accepted at edge N is visible on the out_* ports after edge N.
- Handshake:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - in_ready = !skid_valid (registered).
  - Output payload is stable while out_valid=1 and out_ready=0.
- Buffer rules, per cycle:
  - Main empty or being consumed: accepted input goes to main.
  - Main full and stalled: accepted input goes to skid.
  - Main consumed while skid valid: skid moves to main. A simultaneous new input cannot occur, since in_ready=0.
  - Order is strictly FIFO; no drop, no duplication.
- Flush:
  - Next edge clears out_valid and skid_valid; in_ready=1 afterwards.
  - An input presented in the flush cycle is discarded.
  - An output handshake in the flush cycle still counts as delivered.
- Reset mid-operation: all buffered entries lost immediately (async); payload registers return to 0.
- out_err travels with its entry; it does not block the pipeline.
- in_pc/in_inst/in_fmt are ignored when in_valid=0.

Test Plan:
- XLEN=32, I, inst=0xFFF00093, pc=0x80000000 -> out_imm=0xFFFFFFFF, out_target=0x7FFFFFFF, err=0, one cycle after acceptance.
- J, inst=0x0080006F, pc=0x80000000 -> out_imm=0x00000008, out_target=0x80000008. B, inst=0xFE000EE3, pc=0x80000010 -> out_imm=0xFFFFFFFC, out_target=0x8000000C.
- XLEN=64, U, inst=0x800000B7 -> out_imm=0xFFFFFFFF80000000. SH, inst=0x02009093 -> imm=32, err=0. Same inst with XLEN=32 -> err=1. fmt=7 -> imm=0, err=1.
- Backpressure: out_ready=0, push A, B, C back-to-back -> A in main, B in skid, in_ready=0 while C is held. Release out_ready -> outputs A, B, C in order; in_ready returns to 1.
- flush asserted with main+skid full and in_valid=1 -> next cycle out_valid=0, in_ready=1; the flush-cycle input never appears at the output.
- rst_n pulsed low mid-stream, asynchronously between edges -> out_valid drops immediately, outputs 0. After release, the first new input emerges with 1-cycle latency.

Source files
------------

// File: rtl/imm_gen_stage_if.sv
// Decoder-to-execute channel of the immediate stage: upstream instruction side plus downstream result side.
// The stage connects through the slave modport; the environment drives through master.
interface imm_gen_stage_if #(
   parameter int XLEN  = 32,
   parameter int FMT_W = 3
);
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_inst;
   logic [XLEN-1:0]  in_pc;
   logic [FMT_W-1:0] in_fmt;

   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  out_imm;
   logic [XLEN-1:0]  out_pc;
   logic [XLEN-1:0]  out_target;
   logic             out_err;

   modport master (
      output in_valid, in_inst, in_pc, in_fmt, out_ready,
      input  in_ready, out_valid, out_imm, out_pc, out_target, out_err
   );

   modport slave (
      input  in_valid, in_inst, in_pc, in_fmt, out_ready,
      output in_ready, out_valid, out_imm, out_pc, out_target, out_err
   );
endinterface

// File: rtl/imm_gen_stage.sv
// Immediate generation + pc-relative target, one cycle latency, registered outputs.
// Two-entry skid buffer: in_ready is a flop (low only while the skid entry holds data).
module imm_gen_stage #(
   parameter int XLEN  = 32,
   parameter int FMT_W = 3
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           flush,
   imm_gen_stage_if.slave bus
);

   localparam logic [FMT_W-1:0] FMT_I  = FMT_W'(0);
   localparam logic [FMT_W-1:0] FMT_S  = FMT_W'(1);
   localparam logic [FMT_W-1:0] FMT_B  = FMT_W'(2);
   localparam logic [FMT_W-1:0] FMT_U  = FMT_W'(3);
   localparam logic [FMT_W-1:0] FMT_J  = FMT_W'(4);
   localparam logic [FMT_W-1:0] FMT_Z  = FMT_W'(5);
   localparam logic [FMT_W-1:0] FMT_SH = FMT_W'(6);

   typedef struct packed {
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] tgt;
      logic            err;
   } ent_t;

   logic [31:0] w_inst;
   logic [63:0] w_imm64;
   logic        w_err;
   ent_t        w_new;
   logic        w_in_fire;
   logic        w_out_fire;
   logic        w_unused_bits;

   ent_t        r_main;
   logic        r_main_vld;
   ent_t        r_skid;
   logic        r_skid_vld;
   logic        r_in_rdy;

   assign w_inst = bus.in_inst;

   // Formed at 64 bits and truncated, so one decode serves both XLEN values.
   always_comb begin
      w_imm64 = '0;
      w_err   = 1'b0;
      case (bus.in_fmt)
         FMT_I:  w_imm64 = {{52{w_inst[31]}}, w_inst[31:20]};
         FMT_S:  w_imm64 = {{52{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
         FMT_B:  w_imm64 = {{51{w_inst[31]}}, w_inst[31], w_inst[7], w_inst[30:25],
                            w_inst[11:8], 1'b0};
         FMT_U:  w_imm64 = {{32{w_inst[31]}}, w_inst[31:12], 12'h000};
         FMT_J:  w_imm64 = {{43{w_inst[31]}}, w_inst[31], w_inst[19:12], w_inst[20],
                            w_inst[30:21], 1'b0};
         FMT_Z:  w_imm64 = {59'd0, w_inst[19:15]};
         FMT_SH: begin
            if (XLEN == 64) begin
               w_imm64 = {58'd0, w_inst[25:20]};
            end else begin
               w_imm64 = {59'd0, w_inst[24:20]};
               w_err   = w_inst[25];
            end
         end
         default: begin
            w_imm64 = '0;
            w_err   = 1'b1;
         end
      endcase
   end

   assign w_new.imm = w_imm64[XLEN-1:0];
   assign w_new.pc  = bus.in_pc;
   assign w_new.tgt = bus.in_pc + w_imm64[XLEN-1:0];
   assign w_new.err = w_err;

   // Opcode bits and (for XLEN=32) the upper decode bits carry no immediate information.
   assign w_unused_bits = ^{w_inst[6:0], w_imm64};

   assign w_in_fire  = bus.in_valid & r_in_rdy;
   assign w_out_fire = r_main_vld & bus.out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_main     <= '0;
         r_main_vld <= 1'b0;
         r_skid     <= '0;
         r_skid_vld <= 1'b0;
         r_in_rdy   <= 1'b1;
      end else if (flush) begin
         r_main_vld <= 1'b0;
         r_skid_vld <= 1'b0;
         r_in_rdy   <= 1'b1;
      end else if (!r_main_vld || w_out_fire) begin
         // in_ready is low whenever skid holds data, so a refill from skid never races an input.
         if (r_skid_vld) begin
            r_main     <= r_skid;
            r_main_vld <= 1'b1;
            r_skid_vld <= 1'b0;
            r_in_rdy   <= 1'b1;
         end else begin
            r_main_vld <= w_in_fire;
            if (w_in_fire) begin
               r_main <= w_new;
            end
         end
      end else if (w_in_fire) begin
         r_skid     <= w_new;
         r_skid_vld <= 1'b1;
         r_in_rdy   <= 1'b0;
      end
   end

   assign bus.in_ready   = r_in_rdy;
   assign bus.out_valid  = r_main_vld;
   assign bus.out_imm    = r_main.imm;
   assign bus.out_pc     = r_main.pc;
   assign bus.out_target = r_main.tgt;
   assign bus.out_err    = r_main.err;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: XLEN=32 and XLEN=64 instances driven in lockstep, checked against a
// two-entry FIFO reference model with immediates computed by signed arithmetic.
module tb_imm_gen_stage;

   typedef struct packed {
      logic [63:0] imm;
      logic [63:0] pc;
      logic [63:0] tgt;
      logic        err;
   } ent_t;

   typedef struct {
      bit          w64;
      logic [2:0]  fmt;
      logic [31:0] inst;
      logic [63:0] pc;
      logic [63:0] imm;
      logic [63:0] tgt;
      logic        err;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   logic flush;

   int checks   = 0;
   int failures = 0;

   ent_t mq32[$], mq64[$];
   ent_t ex32[$], ex64[$];
   ent_t gt32[$], gt64[$];

   imm_gen_stage_if #(.XLEN(32), .FMT_W(3)) bus32 ();
   imm_gen_stage_if #(.XLEN(64), .FMT_W(3)) bus64 ();

   imm_gen_stage #(.XLEN(32), .FMT_W(3)) u_dut32 (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (bus32)
   );

   imm_gen_stage #(.XLEN(64), .FMT_W(3)) u_dut64 (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (bus64)
   );

   always #5 clk = ~clk;

   function automatic ent_t ref_ent(logic [31:0] inst, logic [63:0] pc, logic [2:0] fmt, int xlen);
      ent_t        e;
      longint      v;
      logic [63:0] mask;
      e.err = 1'b0;
      v     = 0;
      case (fmt)
         3'd0: v = longint'($signed(inst[31:20]));
         3'd1: v = longint'($signed({inst[31:25], inst[11:7]}));
         3'd2: v = longint'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
         3'd3: v = longint'($signed({inst[31:12], 12'h000}));
         3'd4: v = longint'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
         3'd5: v = longint'(inst[19:15]);
         3'd6: begin
            if (xlen == 64) begin
               v = longint'(inst[25:20]);
            end else begin
               v     = longint'(inst[24:20]);
               e.err = inst[25];
            end
         end
         default: begin
            v     = 0;
            e.err = 1'b1;
         end
      endcase
      mask  = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
      e.imm = 64'(v) & mask;
      e.pc  = pc & mask;
      e.tgt = (pc + 64'(v)) & mask;
      return e;
   endfunction

   function automatic ent_t obs32();
      ent_t e;
      e.imm = {32'd0, bus32.out_imm};
      e.pc  = {32'd0, bus32.out_pc};
      e.tgt = {32'd0, bus32.out_target};
      e.err = bus32.out_err;
      return e;
   endfunction

   function automatic ent_t obs64();
      ent_t e;
      e.imm = bus64.out_imm;
      e.pc  = bus64.out_pc;
      e.tgt = bus64.out_target;
      e.err = bus64.out_err;
      return e;
   endfunction

   // One clock of stimulus: records delivered outputs, then advances the reference FIFO.
   task automatic drive_cycle(bit v, logic [31:0] inst, logic [63:0] pc, logic [2:0] fmt,
                              bit ordy, bit fl);
      int sz;
      @(negedge clk);
      if (bus32.out_valid === 1'b1 && ordy) gt32.push_back(obs32());
      if (bus64.out_valid === 1'b1 && ordy) gt64.push_back(obs64());
      bus32.in_valid  = v;    bus64.in_valid  = v;
      bus32.in_inst   = inst; bus64.in_inst   = inst;
      bus32.in_pc     = pc[31:0];
      bus64.in_pc     = pc;
      bus32.in_fmt    = fmt;  bus64.in_fmt    = fmt;
      bus32.out_ready = ordy; bus64.out_ready = ordy;
      flush = fl;
      sz = mq32.size();
      if (sz != 0 && ordy) begin
         ex32.push_back(mq32.pop_front());
         ex64.push_back(mq64.pop_front());
      end
      if (fl) begin
         mq32.delete();
         mq64.delete();
      end else if (v && sz < 2) begin
         mq32.push_back(ref_ent(inst, pc, fmt, 32));
         mq64.push_back(ref_ent(inst, pc, fmt, 64));
      end
   endtask

   task automatic idle(bit ordy);
      drive_cycle(1'b0, $urandom(), {$urandom(), $urandom()}, 3'($urandom_range(0, 7)), ordy, 1'b0);
   endtask

   task automatic clear_logs();
      ex32.delete(); ex64.delete();
      gt32.delete(); gt64.delete();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      flush = 1'b0;
      bus32.in_valid = 1'b1;  bus64.in_valid = 1'b1;
      bus32.in_inst  = 32'hFFF00093; bus64.in_inst = 32'hFFF00093;
      bus32.in_pc    = 32'h1234; bus64.in_pc = 64'h1234;
      bus32.in_fmt   = 3'd0;  bus64.in_fmt = 3'd0;
      bus32.out_ready = 1'b1; bus64.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({bus32.out_valid, bus32.in_ready, bus32.out_err} !== 3'b010) begin
         failures++;
         $display("FAIL reset_ctrl32 got vld/rdy/err=%b required=010",
                  {bus32.out_valid, bus32.in_ready, bus32.out_err});
      end
      checks++;
      if ({bus32.out_imm, bus32.out_pc, bus32.out_target} !== 96'd0) begin
         failures++;
         $display("FAIL reset_payload32 got=%h required=0",
                  {bus32.out_imm, bus32.out_pc, bus32.out_target});
      end
      checks++;
      if ({bus64.out_valid, bus64.in_ready, bus64.out_err} !== 3'b010) begin
         failures++;
         $display("FAIL reset_ctrl64 got vld/rdy/err=%b required=010",
                  {bus64.out_valid, bus64.in_ready, bus64.out_err});
      end
      checks++;
      if ({bus64.out_imm, bus64.out_pc, bus64.out_target} !== 192'd0) begin
         failures++;
         $display("FAIL reset_payload64 got=%h required=0",
                  {bus64.out_imm, bus64.out_pc, bus64.out_target});
      end
      @(negedge clk);
      bus32.in_valid = 1'b0; bus64.in_valid = 1'b0;
      rst_n = 1'b1;
      mq32.delete(); mq64.delete();
      idle(1'b1);
      @(posedge clk); #1;
      checks++;
      if ({bus32.out_valid, bus64.out_valid, bus32.in_ready, bus64.in_ready} !== 4'b0011) begin
         failures++;
         $display("FAIL post_reset_idle got vld32/vld64/rdy32/rdy64=%b required=0011",
                  {bus32.out_valid, bus64.out_valid, bus32.in_ready, bus64.in_ready});
      end
      clear_logs();
   endtask

   task automatic test_vectors();
      vec_t vt[7];
      ent_t o;
      vt[0] = '{1'b0, 3'd0, 32'hFFF00093, 64'h80000000, 64'hFFFFFFFF, 64'h7FFFFFFF, 1'b0};
      vt[1] = '{1'b0, 3'd4, 32'h0080006F, 64'h80000000, 64'h00000008, 64'h80000008, 1'b0};
      vt[2] = '{1'b0, 3'd2, 32'hFE000EE3, 64'h80000010, 64'hFFFFFFFC, 64'h8000000C, 1'b0};
      vt[3] = '{1'b1, 3'd3, 32'h800000B7, 64'h0, 64'hFFFFFFFF80000000, 64'hFFFFFFFF80000000, 1'b0};
      vt[4] = '{1'b1, 3'd6, 32'h02009093, 64'h0, 64'd32, 64'd32, 1'b0};
      vt[5] = '{1'b0, 3'd6, 32'h02009093, 64'h0, 64'd0, 64'd0, 1'b1};
      vt[6] = '{1'b1, 3'd7, 32'h02009093, 64'h1000, 64'd0, 64'h1000, 1'b1};
      for (int i = 0; i < 7; i++) begin
         drive_cycle(1'b1, vt[i].inst, vt[i].pc, vt[i].fmt, 1'b1, 1'b0);
         @(posedge clk); #1;
         o = vt[i].w64 ? obs64() : obs32();
         checks++;
         if ((vt[i].w64 ? bus64.out_valid : bus32.out_valid) !== 1'b1) begin
            failures++;
            $display("FAIL vec%0d_latency out_valid=%b required=1", i,
                     vt[i].w64 ? bus64.out_valid : bus32.out_valid);
         end
         checks++;
         if ({o.imm, o.tgt, o.err} !== {vt[i].imm, vt[i].tgt, vt[i].err}) begin
            failures++;
            $display("FAIL vec%0d_value got imm=%h tgt=%h err=%b required imm=%h tgt=%h err=%b",
                     i, o.imm, o.tgt, o.err, vt[i].imm, vt[i].tgt, vt[i].err);
         end
      end
      idle(1'b1);
      idle(1'b1);
      clear_logs();
   endtask

   task automatic test_backpressure();
      logic [31:0] inst[3];
      logic [63:0] pc[3];
      logic [2:0]  fmt[3];
      for (int i = 0; i < 3; i++) begin
         inst[i] = $urandom();
         pc[i]   = {$urandom(), $urandom()};
         fmt[i]  = 3'($urandom_range(0, 6));
      end
      drive_cycle(1'b1, inst[0], pc[0], fmt[0], 1'b0, 1'b0);
      drive_cycle(1'b1, inst[1], pc[1], fmt[1], 1'b0, 1'b0);
      drive_cycle(1'b1, inst[2], pc[2], fmt[2], 1'b0, 1'b0);
      @(posedge clk); #1;
      checks++;
      if ({bus32.in_ready, bus64.in_ready} !== 2'b00) begin
         failures++;
         $display("FAIL bp_full_in_ready got=%b required=00", {bus32.in_ready, bus64.in_ready});
      end
      checks++;
      if (obs32() !== ref_ent(inst[0], pc[0], fmt[0], 32) || bus32.out_valid !== 1'b1) begin
         failures++;
         $display("FAIL bp_head_stable got=%h required=%h", obs32(), ref_ent(inst[0], pc[0], fmt[0], 32));
      end
      drive_cycle(1'b1, inst[2], pc[2], fmt[2], 1'b1, 1'b0);
      drive_cycle(1'b1, inst[2], pc[2], fmt[2], 1'b1, 1'b0);
      idle(1'b1);
      idle(1'b1);
      checks++;
      if (gt32.size() != 3 || gt64.size() != 3) begin
         failures++;
         $display("FAIL bp_count got=%0d/%0d required=3/3", gt32.size(), gt64.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (gt32[i] !== ref_ent(inst[i], pc[i], fmt[i], 32) ||
                gt64[i] !== ref_ent(inst[i], pc[i], fmt[i], 64)) begin
               failures++;
               $display("FAIL bp_order%0d got32=%h required32=%h", i, gt32[i],
                        ref_ent(inst[i], pc[i], fmt[i], 32));
            end
         end
      end
      checks++;
      if ({bus32.in_ready, bus64.in_ready} !== 2'b11) begin
         failures++;
         $display("FAIL bp_ready_back got=%b required=11", {bus32.in_ready, bus64.in_ready});
      end
      clear_logs();
   endtask

   task automatic test_flush();
      logic [31:0] a2;
      logic [63:0] pa2;
      drive_cycle(1'b1, $urandom(), {$urandom(), $urandom()}, 3'd0, 1'b0, 1'b0);
      drive_cycle(1'b1, $urandom(), {$urandom(), $urandom()}, 3'd1, 1'b0, 1'b0);
      drive_cycle(1'b1, $urandom(), {$urandom(), $urandom()}, 3'd2, 1'b0, 1'b1);
      @(posedge clk); #1;
      checks++;
      if ({bus32.out_valid, bus64.out_valid, bus32.in_ready, bus64.in_ready} !== 4'b0011) begin
         failures++;
         $display("FAIL flush_clear got vld32/vld64/rdy32/rdy64=%b required=0011",
                  {bus32.out_valid, bus64.out_valid, bus32.in_ready, bus64.in_ready});
      end
      a2  = $urandom();
      pa2 = {$urandom(), $urandom()};
      drive_cycle(1'b1, a2, pa2, 3'd4, 1'b0, 1'b0);
      drive_cycle(1'b1, $urandom(), {$urandom(), $urandom()}, 3'd3, 1'b1, 1'b1);
      repeat (3) idle(1'b1);
      checks++;
      if (gt32.size() != 1 || gt64.size() != 1) begin
         failures++;
         $display("FAIL flush_delivered_count got=%0d/%0d required=1/1", gt32.size(), gt64.size());
      end else begin
         checks++;
         if (gt32[0] !== ref_ent(a2, pa2, 3'd4, 32) || gt64[0] !== ref_ent(a2, pa2, 3'd4, 64)) begin
            failures++;
            $display("FAIL flush_delivered_value got32=%h required32=%h", gt32[0],
                     ref_ent(a2, pa2, 3'd4, 32));
         end
      end
      clear_logs();
   endtask

   task automatic test_reset_midstream();
      logic [31:0] x;
      logic [63:0] px;
      drive_cycle(1'b1, $urandom(), {$urandom(), $urandom()}, 3'd5, 1'b0, 1'b0);
      drive_cycle(1'b1, $urandom(), {$urandom(), $urandom()}, 3'd6, 1'b0, 1'b0);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus32.out_valid, bus64.out_valid, bus32.in_ready, bus64.in_ready} !== 4'b0011) begin
         failures++;
         $display("FAIL arst_ctrl got vld32/vld64/rdy32/rdy64=%b required=0011",
                  {bus32.out_valid, bus64.out_valid, bus32.in_ready, bus64.in_ready});
      end
      checks++;
      if ({obs32(), obs64()} !== '0) begin
         failures++;
         $display("FAIL arst_payload got32=%h got64=%h required=0", obs32(), obs64());
      end
      mq32.delete(); mq64.delete();
      @(posedge clk); #2;
      rst_n = 1'b1;
      x  = $urandom();
      px = {$urandom(), $urandom()};
      drive_cycle(1'b1, x, px, 3'd1, 1'b1, 1'b0);
      @(posedge clk); #1;
      checks++;
      if (bus32.out_valid !== 1'b1 || obs32() !== ref_ent(x, px, 3'd1, 32) ||
          bus64.out_valid !== 1'b1 || obs64() !== ref_ent(x, px, 3'd1, 64)) begin
         failures++;
         $display("FAIL arst_first_after got32=%h v=%b required32=%h", obs32(), bus32.out_valid,
                  ref_ent(x, px, 3'd1, 32));
      end
      idle(1'b1);
      idle(1'b1);
      clear_logs();
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         drive_cycle($urandom_range(0, 9) < 7, $urandom(), {$urandom(), $urandom()},
                     3'($urandom_range(0, 7)), $urandom_range(0, 9) < 6, $urandom_range(0, 31) == 0);
      end
      repeat (4) idle(1'b1);
      checks++;
      if (gt32.size() != ex32.size() || gt64.size() != ex64.size()) begin
         failures++;
         $display("FAIL rand_count got=%0d/%0d required=%0d/%0d", gt32.size(), gt64.size(),
                  ex32.size(), ex64.size());
      end else begin
         for (int i = 0; i < ex32.size(); i++) begin
            checks++;
            if (gt32[i] !== ex32[i]) begin
               failures++;
               $display("FAIL rand32_item%0d got=%h required=%h", i, gt32[i], ex32[i]);
            end
            checks++;
            if (gt64[i] !== ex64[i]) begin
               failures++;
               $display("FAIL rand64_item%0d got=%h required=%h", i, gt64[i], ex64[i]);
            end
         end
      end
      clear_logs();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_vectors();
      test_backpressure();
      test_flush();
      test_reset_midstream();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
